// File: rtl/vram_req_queue.sv
// -----------------------------------------------------------------------------
// vram_req_queue
//
// Request buffer sitting directly upstream of the VRAM arbiter's
// register-interface port. Single-cycle read/write requests from the register
// block are queued in a small circular FIFO. The head entry is presented to
// the arbiter with a sel/ack handshake, and read data is returned with a
// one-cycle valid pulse. The buffer lets register-side writes continue while
// the arbiter is busy serving video fetches.
//
// Parameters
//   DEPTH_LOG2   log2 of FIFO depth (1..4, default 2 -> 4 entries)
//
// Ports
//   clk          system clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   push_i       enqueue strobe (one cycle per request)
//   push_wr_i    1 = write, 0 = read
//   push_mask_i  nibble write mask
//   push_addr_i  VRAM word address
//   push_data_i  write data
//   full_o       FIFO full (registered)
//   empty_o      FIFO empty (registered)
//   count_o      number of entries held
//   overflow_o   sticky flag: a push was attempted while full
//   ovf_clr_i    clears overflow_o (a same-cycle dropped push wins)
//   arb_sel_o    request to the arbiter (= ~empty_o)
//   arb_wr_o     head entry write flag   (0 when empty)
//   arb_mask_o   head entry nibble mask  (0 when empty)
//   arb_addr_o   head entry address      (0 when empty)
//   arb_data_o   head entry write data   (0 when empty)
//   arb_ack_i    arbiter acknowledge; pops the head when not empty
//   vram_data_i  common VRAM read data, valid in the ack cycle
//   rd_data_o    last read result
//   rd_valid_o   one-cycle pulse when rd_data_o has been updated
// -----------------------------------------------------------------------------
module vram_req_queue #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n_i,

    input  logic                  push_i,
    input  logic                  push_wr_i,
    input  logic [3:0]            push_mask_i,
    input  logic [15:0]           push_addr_i,
    input  logic [15:0]           push_data_i,

    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    input  logic                  ovf_clr_i,

    output logic                  arb_sel_o,
    output logic                  arb_wr_o,
    output logic [3:0]            arb_mask_o,
    output logic [15:0]           arb_addr_o,
    output logic [15:0]           arb_data_o,
    input  logic                  arb_ack_i,

    input  logic [15:0]           vram_data_i,
    output logic [15:0]           rd_data_o,
    output logic                  rd_valid_o
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;

    typedef struct packed {
        logic       wr;
        logic [3:0] mask;
        addr_t      addr;
        word_t      data;
    } req_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    req_t                  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q;
    logic [DEPTH_LOG2-1:0] tail_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  full_q;
    logic                  empty_q;
    logic                  ovf_q;
    word_t                 rd_data_q;
    logic                  rd_valid_q;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    req_t                head_req;
    req_t                push_req;
    logic                push_ok;
    logic                push_drop;
    logic                pop;
    logic [DEPTH_LOG2:0] count_nxt;

    assign head_req = mem[head_q];
    assign push_req = '{wr: push_wr_i, mask: push_mask_i, addr: push_addr_i, data: push_data_i};

    // Both decisions use the registered flags, so a push while full is dropped
    // even when the head pops in the same cycle, and a stale ack into an empty
    // queue is ignored.
    assign push_ok   = push_i & ~full_q;
    assign push_drop = push_i &  full_q;
    assign pop       = arb_ack_i & ~empty_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;   // idle, or push and pop together
        endcase
    end

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only ever observed
    // after it has been written, and the head outputs are forced to zero
    // while the queue is empty, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail_q] <= push_req;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, occupancy and status flags
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking assignments so all
    // flops sample the pre-edge values of each other regardless of order.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            // Pointers are exactly DEPTH_LOG2 bits wide, so the increment
            // wraps modulo the depth on its own.
            if (push_ok) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_CNT);
            empty_q <= (count_nxt == '0);
        end
    end

    // Sticky overflow: a dropped push takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ovf_q <= 1'b0;
        end else if (push_drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Read return: VRAM data is valid in the ack cycle, so it is captured on
    // the popping edge of a read and flagged for exactly the next cycle.
    // Write pops leave rd_data_o untouched.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop & ~head_req.wr;
            if (pop && !head_req.wr) begin
                rd_data_q <= vram_data_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. arb_sel_o comes straight from the registered empty flag; a push
    // into an empty queue therefore requests the arbiter one cycle later.
    // Head fields are zeroed while empty so the bus never shows stale entries.
    // -------------------------------------------------------------------------
    always_comb begin
        arb_wr_o   = 1'b0;
        arb_mask_o = '0;
        arb_addr_o = '0;
        arb_data_o = '0;
        if (!empty_q) begin
            arb_wr_o   = head_req.wr;
            arb_mask_o = head_req.mask;
            arb_addr_o = head_req.addr;
            arb_data_o = head_req.data;
        end
    end

    assign arb_sel_o  = ~empty_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule
